// File: rtl/writeback_buffer_stage.sv
// Writeback stage with a DEPTH-entry in-order result buffer draining to the
// register-file write port, plus two forwarding lookups over pending entries.
module writeback_buffer_stage #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_we,
    input  logic [ADDR_W-1:0]            in_dest,
    input  logic [1:0]                   in_sel,
    input  logic [DATA_W-1:0]            in_alu,
    input  logic [DATA_W-1:0]            in_mem,
    input  logic [DATA_W-1:0]            in_link,
    input  logic [DATA_W-1:0]            in_imm,
    output logic                         wb_valid,
    input  logic                         wb_ready,
    output logic [ADDR_W-1:0]            wb_dest,
    output logic [DATA_W-1:0]            wb_data,
    input  logic [ADDR_W-1:0]            fwd_addr_a,
    output logic                         fwd_hit_a,
    output logic [DATA_W-1:0]            fwd_data_a,
    input  logic [ADDR_W-1:0]            fwd_addr_b,
    output logic                         fwd_hit_b,
    output logic [DATA_W-1:0]            fwd_data_b,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [ADDR_W-1:0] dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              accept, enq, pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [DATA_W-1:0] src_mux(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] alu,
        input logic [DATA_W-1:0] mem,
        input logic [DATA_W-1:0] link,
        input logic [DATA_W-1:0] imm
    );
        case (sel)
            2'd0:    return alu;
            2'd1:    return mem;
            2'd2:    return link;
            default: return imm;
        endcase
    endfunction

    // Walks entries oldest to youngest so the last match wins.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] addr);
        logic              hit;
        logic [DATA_W-1:0] data;
        logic [PTR_W-1:0]  idx;
        hit  = 1'b0;
        data = '0;
        idx  = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(occ_q) && dest_q[idx] == addr) begin
                hit  = 1'b1;
                data = data_q[idx];
            end
            idx = ptr_inc(idx);
        end
        return {hit, data};
    endfunction

    always_comb begin
        in_ready  = !rst && ((occ_q < FULL_OCC) || wb_ready);
        wb_valid  = (occ_q != '0);
        wb_dest   = dest_q[head_q];
        wb_data   = data_q[head_q];
        occupancy = occ_q;
        accept    = in_valid && in_ready;
        enq       = accept && in_we;
        pop       = wb_valid && wb_ready;
        head_d    = pop ? ptr_inc(head_q) : head_q;
        tail_d    = enq ? ptr_inc(tail_q) : tail_q;
        occ_d     = occ_q;
        case ({enq, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        {fwd_hit_a, fwd_data_a} = lookup(fwd_addr_a);
        {fwd_hit_b, fwd_data_b} = lookup(fwd_addr_b);
    end

    // Popped slots are zeroed so an empty buffer presents zero on the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            if (pop) begin
                dest_q[head_q] <= '0;
                data_q[head_q] <= '0;
            end
            if (enq) begin
                dest_q[tail_q] <= in_dest;
                data_q[tail_q] <= src_mux(in_sel, in_alu, in_mem, in_link, in_imm);
            end
        end
    end

endmodule

// File: tb/tb_writeback_buffer_stage.sv
// Scoreboard bench for writeback_buffer_stage: a DEPTH=2 and a DEPTH=3 instance
// share the upstream stimulus; each has its own wb_ready and reference queue.
module tb_writeback_buffer_stage;

    localparam int DW = 24;
    localparam int AW = 4;

    typedef struct packed {
        logic [AW-1:0] d;
        logic [DW-1:0] v;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_we;
    logic [AW-1:0] in_dest, fwd_addr_a, fwd_addr_b;
    logic [1:0]    in_sel;
    logic [DW-1:0] in_alu, in_mem, in_link, in_imm;
    logic          wb_ready2, wb_ready3;

    logic          in_ready2, wb_valid2, hit_a2, hit_b2;
    logic [AW-1:0] wb_dest2;
    logic [DW-1:0] wb_data2, data_a2, data_b2;
    logic [1:0]    occ2;
    logic          in_ready3, wb_valid3, hit_a3, hit_b3;
    logic [AW-1:0] wb_dest3;
    logic [DW-1:0] wb_data3, data_a3, data_b3;
    logic [1:0]    occ3;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    ent_t q2[$];
    ent_t q3[$];

    always #5 clk = ~clk;

    writeback_buffer_stage #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_we(in_we),
        .in_dest(in_dest), .in_sel(in_sel), .in_alu(in_alu), .in_mem(in_mem),
        .in_link(in_link), .in_imm(in_imm), .wb_valid(wb_valid2), .wb_ready(wb_ready2),
        .wb_dest(wb_dest2), .wb_data(wb_data2), .fwd_addr_a(fwd_addr_a), .fwd_hit_a(hit_a2),
        .fwd_data_a(data_a2), .fwd_addr_b(fwd_addr_b), .fwd_hit_b(hit_b2),
        .fwd_data_b(data_b2), .occupancy(occ2)
    );

    writeback_buffer_stage #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .in_we(in_we),
        .in_dest(in_dest), .in_sel(in_sel), .in_alu(in_alu), .in_mem(in_mem),
        .in_link(in_link), .in_imm(in_imm), .wb_valid(wb_valid3), .wb_ready(wb_ready3),
        .wb_dest(wb_dest3), .wb_data(wb_data3), .fwd_addr_a(fwd_addr_a), .fwd_hit_a(hit_a3),
        .fwd_data_a(data_a3), .fwd_addr_b(fwd_addr_b), .fwd_hit_b(hit_b3),
        .fwd_data_b(data_b3), .occupancy(occ3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mux_ref(input logic [1:0] sel);
        case (sel)
            2'd0:    return in_alu;
            2'd1:    return in_mem;
            2'd2:    return in_link;
            default: return in_imm;
        endcase
    endfunction

    // Compare one instance against its reference queue, then apply the
    // transfers that the coming edge will perform.
    task automatic mon(input string nm, ref ent_t q[$], input int depth,
                       input logic rdy, input logic wv, input logic wr,
                       input logic [AW-1:0] wd, input logic [DW-1:0] wdat,
                       input logic [1:0] occ, input logic ha, input logic [DW-1:0] da,
                       input logic hb, input logic [DW-1:0] db);
        logic          eha, ehb;
        logic [DW-1:0] eda, edb;
        eha = 1'b0; ehb = 1'b0; eda = '0; edb = '0;
        foreach (q[i]) begin
            if (q[i].d == fwd_addr_a) begin eha = 1'b1; eda = q[i].v; end
            if (q[i].d == fwd_addr_b) begin ehb = 1'b1; edb = q[i].v; end
        end
        check({nm, ".occ"}, 32'(occ), 32'(q.size()));
        check({nm, ".wb_valid"}, 32'(wv), 32'(q.size() != 0));
        check({nm, ".in_ready"}, 32'(rdy), 32'(!rst && (q.size() < depth || wr)));
        check({nm, ".hit_a"}, 32'(ha), 32'(eha));
        check({nm, ".data_a"}, 32'(da), 32'(eda));
        check({nm, ".hit_b"}, 32'(hb), 32'(ehb));
        check({nm, ".data_b"}, 32'(db), 32'(edb));
        if (q.size() == 0) begin
            check({nm, ".empty_dest"}, 32'(wd), 32'h0);
            check({nm, ".empty_data"}, 32'(wdat), 32'h0);
        end
        if (rst) begin
            q.delete();
        end else begin
            if (wv && wr) begin
                if (q.size() == 0) begin
                    check({nm, ".pop_empty"}, 32'(1), 32'(0));
                end else begin
                    check({nm, ".drain_dest"}, 32'(wd), 32'(q[0].d));
                    check({nm, ".drain_data"}, 32'(wdat), 32'(q[0].v));
                    void'(q.pop_front());
                end
            end
            if (in_valid && rdy && in_we) q.push_back('{d: in_dest, v: mux_ref(in_sel)});
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon("d2", q2, 2, in_ready2, wb_valid2, wb_ready2, wb_dest2, wb_data2, occ2,
                hit_a2, data_a2, hit_b2, data_b2);
            mon("d3", q3, 3, in_ready3, wb_valid3, wb_ready3, wb_dest3, wb_data3, occ3,
                hit_a3, data_a3, hit_b3, data_b3);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] exp_src [4];
        int            idx, guard, max_occ;
        logic          acc;
        exp_src = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};

        rst = 1'b1; in_valid = 1'b0; in_we = 1'b0; in_dest = '0; in_sel = '0;
        in_alu = '0; in_mem = '0; in_link = '0; in_imm = '0;
        fwd_addr_a = '0; fwd_addr_b = 4'd15; wb_ready2 = 1'b1; wb_ready3 = 1'b1;
        step(); step();
        rst = 1'b0;
        mon_en = 1'b1;
        #1;
        check("reset.wb_valid", 32'(wb_valid2), 32'h0);
        check("reset.occ", 32'(occ2), 32'h0);

        // Single write through the mem source
        in_valid = 1'b1; in_we = 1'b1; in_dest = 4'd3; in_sel = 2'd1; in_mem = 24'h00ABCD;
        #1;
        check("t1.no_comb_path", 32'(wb_valid2), 32'h0);
        step();
        in_valid = 1'b0;
        check("t1.wb_valid", 32'(wb_valid2), 32'h1);
        check("t1.wb_dest", 32'(wb_dest2), 32'h3);
        check("t1.wb_data", 32'(wb_data2), 32'h00ABCD);
        step();
        check("t1.drained", 32'(wb_valid2), 32'h0);

        // Each select value; sources change after accept
        for (int s = 0; s < 4; s++) begin
            wb_ready2 = 1'b0;
            in_alu = 24'h111111; in_mem = 24'h222222; in_link = 24'h333333; in_imm = 24'h444444;
            in_sel = 2'(s); in_dest = 4'(s + 4); in_valid = 1'b1; in_we = 1'b1;
            step();
            in_valid = 1'b0;
            in_alu = 24'hAAAAAA; in_mem = 24'hBBBBBB; in_link = 24'hCCCCCC; in_imm = 24'hDDDDDD;
            step();
            check("t2.sel_data", 32'(wb_data2), 32'(exp_src[s]));
            wb_ready2 = 1'b1;
            step();
        end

        // Backpressure, forwarding, same-cycle pop+accept
        wb_ready2 = 1'b0; wb_ready3 = 1'b0; in_sel = 2'd0; in_we = 1'b1; in_valid = 1'b1;
        in_dest = 4'd1; in_alu = 24'h10;
        step();
        in_dest = 4'd2; in_alu = 24'h20;
        step();
        in_dest = 4'd1; in_alu = 24'h30; fwd_addr_a = 4'd1; fwd_addr_b = 4'd2;
        #1;
        check("t3.occ_full", 32'(occ2), 32'h2);
        check("t3.ready_full", 32'(in_ready2), 32'h0);
        check("t3.fwd_hit", 32'(hit_a2), 32'h1);
        check("t3.fwd_data", 32'(data_a2), 32'h10);
        check("t3.head_dest", 32'(wb_dest2), 32'h1);
        check("t3.head_data", 32'(wb_data2), 32'h10);
        wb_ready2 = 1'b1;
        #1;
        check("t3.ready_pop", 32'(in_ready2), 32'h1);
        step();
        in_valid = 1'b0;
        check("t3.d3_fwd_hit", 32'(hit_a3), 32'h1);
        check("t3.d3_fwd_youngest", 32'(data_a3), 32'h30);
        check("t3.occ_after", 32'(occ2), 32'h2);
        check("t3.drain2_dest", 32'(wb_dest2), 32'h2);
        check("t3.drain2_data", 32'(wb_data2), 32'h20);
        step();
        check("t3.drain3_dest", 32'(wb_dest2), 32'h1);
        check("t3.drain3_data", 32'(wb_data2), 32'h30);
        check("t3.fwd_last", 32'(data_a2), 32'h30);
        step();
        check("t3.empty", 32'(wb_valid2), 32'h0);
        wb_ready3 = 1'b1;
        step(); step(); step();
        check("t3.d3_empty", 32'(occ3), 32'h0);

        // Write-less instruction while empty
        in_valid = 1'b1; in_we = 1'b0; in_dest = 4'd5;
        #1;
        check("t4.ready", 32'(in_ready2), 32'h1);
        step();
        in_valid = 1'b0;
        check("t4.occ", 32'(occ2), 32'h0);
        check("t4.wb_valid", 32'(wb_valid2), 32'h0);
        check("t4.ready_after", 32'(in_ready2), 32'h1);

        // Reset while full
        wb_ready2 = 1'b0; in_valid = 1'b1; in_we = 1'b1; in_sel = 2'd3;
        in_dest = 4'd6; in_imm = 24'h66;
        step();
        in_dest = 4'd7; in_imm = 24'h77;
        step();
        fwd_addr_a = 4'd6; fwd_addr_b = 4'd7;
        check("t5.full", 32'(occ2), 32'h2);
        check("t5.valid", 32'(wb_valid2), 32'h1);
        rst = 1'b1;
        #1;
        check("t5.ready_in_rst", 32'(in_ready2), 32'h0);
        step();
        rst = 1'b0; in_valid = 1'b0;
        check("t5.occ", 32'(occ2), 32'h0);
        check("t5.wb_valid", 32'(wb_valid2), 32'h0);
        check("t5.wb_data", 32'(wb_data2), 32'h0);
        check("t5.hit_a", 32'(hit_a2), 32'h0);
        check("t5.hit_b", 32'(hit_b2), 32'h0);
        wb_ready2 = 1'b1;

        // Pointer wrap on the DEPTH=3 instance with toggling wb_ready
        idx = 0; guard = 0; max_occ = 0; in_sel = 2'd0; in_we = 1'b1;
        while (idx < 10 && guard < 200) begin
            in_valid = 1'b1; in_dest = 4'(idx % 16); in_alu = DW'(idx);
            fwd_addr_a = 4'((idx + 15) % 16); fwd_addr_b = 4'($urandom_range(0, 15));
            wb_ready3 = ~wb_ready3;
            #1;
            acc = in_ready3;
            if (int'(occ3) > max_occ) max_occ = int'(occ3);
            step();
            if (acc) idx++;
            guard++;
        end
        in_valid = 1'b0;
        check("t6.all_accepted", 32'(idx), 32'd10);
        wb_ready3 = 1'b1;
        guard = 0;
        while (occ3 != 2'd0 && guard < 20) begin
            step();
            guard++;
        end
        check("t6.max_occ_le3", 32'(max_occ <= 3), 32'h1);
        check("t6.drained", 32'(occ3), 32'h0);
        check("t6.no_loss", 32'(q3.size()), 32'h0);
        step();

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/writeback_buffer_stage.md
Name: writeback_buffer_stage

Overview:
- Parametrised successor to the combinational writeback stage.
- Selects the writeback value from one of four result sources and registers the result into a DEPTH-entry in-order buffer.
- Drains the buffer to the register-file write port with a valid/ready handshake, so a busy write port no longer stalls the stage combinationally.
- Provides two forwarding lookup ports so hazard logic can bypass data that is still pending.
- Sits between the memory stage and the register file.

Parameters:
- DATA_W, 24, width of all data paths.
- ADDR_W, 4, register-address width.
- DEPTH, 2, number of buffer entries; legal range 1..8.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  upstream offers a retiring instruction.
- in_ready  output  1  stage accepts this cycle.
- in_we  input  1  instruction writes a register.
- in_dest  input  ADDR_W  destination register.
- in_sel  input  2  source select: 0 = alu, 1 = mem, 2 = link, 3 = imm.
- in_alu  input  DATA_W  ALU result.
- in_mem  input  DATA_W  memory read data.
- in_link  input  DATA_W  link/return address.
- in_imm  input  DATA_W  immediate passthrough.
- wb_valid  output  1  buffer head is valid.
- wb_ready  input  1  register file accepts the head this cycle.
- wb_dest  output  ADDR_W  head destination.
- wb_data  output  DATA_W  head data.
- fwd_addr_a  input  ADDR_W  lookup address, port A.
- fwd_hit_a  output  1  a pending entry matches fwd_addr_a.
- fwd_data_a  output  DATA_W  data of the youngest matching entry, port A.
- fwd_addr_b  input  ADDR_W  lookup address, port B.
- fwd_hit_b  output  1  a pending entry matches fwd_addr_b.
- fwd_data_b  output  DATA_W  data of the youngest matching entry, port B.
- occupancy  output  clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Transfer rules:
  - accept = in_valid && in_ready.
  - pop = wb_valid && wb_ready.
- Data mux: applied at accept time and stored; sources are not re-sampled afterwards.
- Entries without a write:
  - An accepted instruction with in_we = 0 is consumed and discarded.
  - It causes no enqueue and no occupancy change.
  - in_ready is still honoured for it.
- Buffer: circular, with head/tail pointers wrapping modulo DEPTH (DEPTH need not be a power of 2). Strictly in-order.
- in_ready = (occupancy < DEPTH) || wb_ready.
  - When full, a same-cycle pop frees the slot.
  - in_ready depends combinationally on wb_ready only; it never depends on in_valid.
- Simultaneous events:
  - accept with we plus pop: occupancy unchanged, head and tail both advance.
  - accept with we = 0 plus pop: occupancy decrements.
- Latency:
  - Minimum latency is 1 cycle: an entry accepted in cycle N appears as the head in cycle N+1 at the earliest.
  - There is no combinational in→wb path.
- Head outputs:
  - wb_valid = (occupancy != 0).
  - wb_dest and wb_data come from the head slot.
  - When empty, wb_dest and wb_data hold 0, so storage is zeroed on reset and on each pop.
- Head stability: the head must hold stable while wb_valid && !wb_ready.
- Forwarding lookup:
  - Combinational search over the valid entries only.
  - The incoming (not yet accepted) instruction is excluded.
  - hit = any valid entry with dest == addr.
  - data = the youngest such entry (closest to tail), else 0.
  - An entry popped this cycle still counts as a hit this cycle.
  - Address 0 receives no special treatment.
- Reset:
  - rst high at a clock edge clears the pointers and occupancy to 0 and zeroes storage.
  - After that edge: wb_valid = 0, wb_dest = 0, wb_data = 0, fwd hits = 0, occupancy = 0.
  - Reset mid-drain discards all pending entries.
  - While rst is high, in_ready = 0 and no accept occurs.

Test Plan:
- Reset, then in_valid = 1, in_we = 1, in_dest = 3, in_sel = 1, in_mem = 0x00ABCD, with wb_ready = 1.
  - Next cycle: wb_valid = 1, wb_dest = 3, wb_data = 0x00ABCD.
  - Following cycle: wb_valid = 0.
- Each in_sel value 0..3 with distinct source values (alu = 0x111111, mem = 0x222222, link = 0x333333, imm = 0x444444) -> wb_data equals the selected value; the other sources are changed after accept with no effect.
- wb_ready = 0, DEPTH = 2, three back-to-back writes to r1, r2, r1 (data 0x10, 0x20, 0x30):
  - After two accepts: occupancy = 2 and in_ready = 0.
  - fwd_addr_a = 1 gives hit = 1, data = 0x10.
  - Raise wb_ready: the 3rd write is accepted the same cycle the head pops.
  - Drain order on wb_dest/wb_data is 1/0x10, 2/0x20, 1/0x30.
  - While both r1 entries are pending, fwd_addr_a = 1 returns 0x30.
- in_we = 0 accepted while empty -> occupancy stays 0, wb_valid stays 0, in_ready stays 1.
- Full buffer with wb_valid = 1 and rst asserted one cycle -> next cycle occupancy = 0, wb_valid = 0, wb_data = 0, fwd_hit_a = fwd_hit_b = 0.
- Pointer wrap with DEPTH = 3: stream 10 writes (dest = i mod 16, data = i) while wb_ready toggles every cycle -> all 10 retire in order with no loss or duplication, and occupancy never exceeds 3.
